// File: rtl/lcd_read_ctrl_if.sv
// LCD bus bundle between the read controller and the data/control pads.
// The controller drives RW/EN/RS and reads the pad input path.
interface lcd_read_ctrl_if;
    logic [7:0] LCD_DATA_IN;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;

    modport master (
        input  LCD_DATA_IN,
        output LCD_RW,
        output LCD_EN,
        output LCD_RS
    );

    modport slave (
        output LCD_DATA_IN,
        input  LCD_RW,
        input  LCD_EN,
        input  LCD_RS
    );
endinterface

// File: rtl/lcd_read_ctrl.sv
// HD44780-style LCD read-cycle controller: setup -> EN pulse -> sample -> hold -> done.
// Optional busy-flag polling is built when LCD_READ_BUSY_POLL_EN is defined.
module lcd_read_ctrl #(
    parameter int CLK_Divide   = 16,
    parameter int SETUP_CYC    = 2,
    parameter int HOLD_CYC     = 2,
    parameter int POLL_TIMEOUT = 255
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iRS,
    input  logic             iStart,
    input  logic             iPoll,
    output logic [7:0]       oDATA,
    output logic             oDone,
    output logic             oTimeout,
    output logic [2:0]       oDbgState,
    lcd_read_ctrl_if.master  lcd
);

    localparam int MAX_AB  = (CLK_Divide > SETUP_CYC) ? CLK_Divide : SETUP_CYC;
    localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SETUP = 3'd2,
        ENH   = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e        state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic          preStart;
    logic          rwReg, rwNext;
    logic          enReg, enNext;
    logic          rsReg, rsNext;
    logic [7:0]    dataNext;
    logic          doneNext;
    logic          startEdge;

    // Handshake: a rising edge on iStart is accepted only in IDLE/DONE;
    // oDone is a level that stays high until the next accepted start.
    assign startEdge = iStart & ~preStart;

`ifdef LCD_READ_BUSY_POLL_EN
    logic       pollReg, pollNext;
    logic       toReg, toNext;
    logic [7:0] attempt, attemptNext;
    assign oTimeout = toReg;
`else
    logic unusedPoll;
    assign unusedPoll = iPoll;
    assign oTimeout   = 1'b0;
`endif

    assign lcd.LCD_RW = rwReg;
    assign lcd.LCD_EN = enReg;
    assign lcd.LCD_RS = rsReg;
    assign oDbgState  = state;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state    <= IDLE;
            cnt      <= '0;
            preStart <= 1'b0;
            rwReg    <= 1'b0;
            enReg    <= 1'b0;
            rsReg    <= 1'b0;
            oDATA    <= 8'h00;
            oDone    <= 1'b0;
`ifdef LCD_READ_BUSY_POLL_EN
            pollReg  <= 1'b0;
            toReg    <= 1'b0;
            attempt  <= 8'h00;
`endif
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            preStart <= iStart;
            rwReg    <= rwNext;
            enReg    <= enNext;
            rsReg    <= rsNext;
            oDATA    <= dataNext;
            oDone    <= doneNext;
`ifdef LCD_READ_BUSY_POLL_EN
            pollReg  <= pollNext;
            toReg    <= toNext;
            attempt  <= attemptNext;
`endif
        end
    end

    always_comb begin
        stateNext   = state;
        cntNext     = cnt + 1'b1;
        rwNext      = rwReg;
        enNext      = enReg;
        rsNext      = rsReg;
        dataNext    = oDATA;
        doneNext    = oDone;
`ifdef LCD_READ_BUSY_POLL_EN
        pollNext    = pollReg;
        toNext      = toReg;
        attemptNext = attempt;
`endif
        case (state)
            IDLE, DONE: begin
                cntNext = '0;
                if (startEdge) begin
                    stateNext   = START;
                    doneNext    = 1'b0;
`ifdef LCD_READ_BUSY_POLL_EN
                    toNext      = 1'b0;
                    pollNext    = iPoll;
                    attemptNext = 8'h00;
                    // Busy-flag reads always address the instruction register.
                    rsNext      = iPoll ? 1'b0 : iRS;
`else
                    rsNext      = iRS;
`endif
                end
            end
            START: begin
                rwNext    = 1'b1;
                cntNext   = '0;
                stateNext = SETUP;
            end
            SETUP: begin
                if (cnt == CW'(SETUP_CYC - 1)) begin
                    enNext    = 1'b1;
                    cntNext   = '0;
                    stateNext = ENH;
                end
            end
            ENH: begin
                if (cnt == CW'(CLK_Divide - 1)) begin
                    enNext    = 1'b0;
                    dataNext  = lcd.LCD_DATA_IN;
                    cntNext   = '0;
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (cnt == CW'(HOLD_CYC - 1)) begin
                    cntNext = '0;
`ifdef LCD_READ_BUSY_POLL_EN
                    if (pollReg && oDATA[7]) begin
                        if (attempt == 8'(POLL_TIMEOUT - 1)) begin
                            rwNext    = 1'b0;
                            doneNext  = 1'b1;
                            toNext    = 1'b1;
                            stateNext = DONE;
                        end else begin
                            attemptNext = attempt + 8'd1;
                            stateNext   = SETUP;
                        end
                    end else begin
                        rwNext    = 1'b0;
                        doneNext  = 1'b1;
                        stateNext = DONE;
                    end
`else
                    rwNext    = 1'b0;
                    doneNext  = 1'b1;
                    stateNext = DONE;
`endif
                end
            end
            default: begin
                cntNext   = '0;
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Directed bench for lcd_read_ctrl; busy-poll cases build when LCD_READ_BUSY_POLL_EN is defined.
module tb_lcd_read_ctrl;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iRS = 1'b0;
    logic       iStart = 1'b0;
    logic       iPoll = 1'b0;
    logic [7:0] oDATA;
    logic       oDone;
    logic       oTimeout;
    logic [2:0] dbgState;

    int nVec = 0;
    int nErr = 0;
    int enPulses = 0;
    int base = 0;
    logic enPrev = 1'b0;

    lcd_read_ctrl_if lcdBus ();

    lcd_read_ctrl #(
        .CLK_Divide   (16),
        .SETUP_CYC    (2),
        .HOLD_CYC     (2),
        .POLL_TIMEOUT (4)
    ) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iRS       (iRS),
        .iStart    (iStart),
        .iPoll     (iPoll),
        .oDATA     (oDATA),
        .oDone     (oDone),
        .oTimeout  (oTimeout),
        .oDbgState (dbgState),
        .lcd       (lcdBus)
    );

    always #5 iCLK = ~iCLK;

    // EN rising-edge counter
    always @(posedge iCLK) begin
        if (lcdBus.LCD_EN && !enPrev) enPulses = enPulses + 1;
        enPrev = lcdBus.LCD_EN;
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns one tick after the accepted-start edge E (relative cycle 0).
    task automatic start_read(input logic rs, input logic poll);
        iRS    = rs;
        iPoll  = poll;
        iStart = 1'b0;
        tick();
        iStart = 1'b1;
        tick();
    endtask

    initial begin
        lcdBus.LCD_DATA_IN = 8'h00;

        // 1: reset with iStart toggling
        iRST_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iStart = ~iStart;
            tick();
        end
        check("rst_data", oDATA, 8'h00);
        check("rst_done", {7'd0, oDone}, 8'h00);
        check("rst_to", {7'd0, oTimeout}, 8'h00);
        check("rst_en", {7'd0, lcdBus.LCD_EN}, 8'h00);
        check("rst_rw", {7'd0, lcdBus.LCD_RW}, 8'h00);
        check("rst_rs", {7'd0, lcdBus.LCD_RS}, 8'h00);
        check("rst_state", {5'd0, dbgState}, 8'h00);
        check("rst_pulses", 8'(enPulses), 8'd0);
        iStart = 1'b0;
        iRST_N = 1'b1;
        tick();

        // 2: single read, iRS=1, data A5, iStart held high afterwards
        lcdBus.LCD_DATA_IN = 8'hA5;
        base = enPulses;
        start_read(1'b1, 1'b0);
        check("t2_done_k0", {7'd0, oDone}, 8'h00);
        check("t2_rw_k0", {7'd0, lcdBus.LCD_RW}, 8'h00);
        tick();
        check("t2_rw_k1", {7'd0, lcdBus.LCD_RW}, 8'h01);
        check("t2_rs_k1", {7'd0, lcdBus.LCD_RS}, 8'h01);
        iRS = 1'b0;
        tick();
        check("t2_en_k2", {7'd0, lcdBus.LCD_EN}, 8'h00);
        tick();
        check("t2_en_k3", {7'd0, lcdBus.LCD_EN}, 8'h01);
        repeat (15) tick();
        check("t2_en_k18", {7'd0, lcdBus.LCD_EN}, 8'h01);
        tick();
        check("t2_en_k19", {7'd0, lcdBus.LCD_EN}, 8'h00);
        check("t2_data_k19", oDATA, 8'hA5);
        tick();
        check("t2_done_k20", {7'd0, oDone}, 8'h00);
        check("t2_rw_k20", {7'd0, lcdBus.LCD_RW}, 8'h01);
        tick();
        check("t2_done_k21", {7'd0, oDone}, 8'h01);
        check("t2_rw_k21", {7'd0, lcdBus.LCD_RW}, 8'h00);
        check("t2_rs_held", {7'd0, lcdBus.LCD_RS}, 8'h01);
        repeat (5) tick();
        check("t2_single", 8'(enPulses - base), 8'd1);
        check("t2_done_held", {7'd0, oDone}, 8'h01);

        // 3: sample is the value present during the last EN-high cycle
        lcdBus.LCD_DATA_IN = 8'h11;
        start_read(1'b1, 1'b0);
        repeat (18) tick();
        lcdBus.LCD_DATA_IN = 8'h3C;
        tick();
        lcdBus.LCD_DATA_IN = 8'hFF;
        check("t3_data_k19", oDATA, 8'h3C);
        repeat (2) tick();
        check("t3_data_k21", oDATA, 8'h3C);
        check("t3_done", {7'd0, oDone}, 8'h01);

        // 4: mid-cycle start edge ignored; later edge restarts
        lcdBus.LCD_DATA_IN = 8'h96;
        base = enPulses;
        start_read(1'b0, 1'b0);
        repeat (6) tick();
        iStart = 1'b0;
        tick();
        iStart = 1'b1;
        repeat (14) tick();
        check("t4_done", {7'd0, oDone}, 8'h01);
        check("t4_pulses1", 8'(enPulses - base), 8'd1);
        check("t4_data1", oDATA, 8'h96);
        check("t4_rs0", {7'd0, lcdBus.LCD_RS}, 8'h00);
        lcdBus.LCD_DATA_IN = 8'h69;
        start_read(1'b1, 1'b0);
        check("t4_done_clr", {7'd0, oDone}, 8'h00);
        repeat (21) tick();
        check("t4_done2", {7'd0, oDone}, 8'h01);
        check("t4_data2", oDATA, 8'h69);
        check("t4_pulses2", 8'(enPulses - base), 8'd2);

        // 5: reset while EN high, then a normal cycle
        lcdBus.LCD_DATA_IN = 8'hC3;
        start_read(1'b1, 1'b0);
        repeat (10) tick();
        check("t5_en_pre", {7'd0, lcdBus.LCD_EN}, 8'h01);
        iRST_N = 1'b0;
        tick();
        check("t5_en_rst", {7'd0, lcdBus.LCD_EN}, 8'h00);
        check("t5_rw_rst", {7'd0, lcdBus.LCD_RW}, 8'h00);
        check("t5_data_rst", oDATA, 8'h00);
        iRST_N = 1'b1;
        lcdBus.LCD_DATA_IN = 8'h5A;
        base = enPulses;
        start_read(1'b0, 1'b0);
        repeat (20) tick();
        check("t5_done_k20", {7'd0, oDone}, 8'h00);
        tick();
        check("t5_done_k21", {7'd0, oDone}, 8'h01);
        check("t5_data", oDATA, 8'h5A);
        check("t5_rw", {7'd0, lcdBus.LCD_RW}, 8'h00);
        check("t5_pulses", 8'(enPulses - base), 8'd1);

`ifdef LCD_READ_BUSY_POLL_EN
        // 6a: BF=1 for three reads, then 07
        lcdBus.LCD_DATA_IN = 8'h80;
        base = enPulses;
        start_read(1'b1, 1'b1);
        tick();
        check("t6a_rs_forced", {7'd0, lcdBus.LCD_RS}, 8'h00);
        for (int i = 0; i < 400 && !oDone; i++) begin
            if (enPulses - base == 4) lcdBus.LCD_DATA_IN = 8'h07;
            tick();
        end
        check("t6a_done", {7'd0, oDone}, 8'h01);
        check("t6a_pulses", 8'(enPulses - base), 8'd4);
        check("t6a_data", oDATA, 8'h07);
        check("t6a_to", {7'd0, oTimeout}, 8'h00);

        // 6b: BF stuck at 1 with POLL_TIMEOUT=4
        lcdBus.LCD_DATA_IN = 8'hFF;
        base = enPulses;
        start_read(1'b0, 1'b1);
        for (int i = 0; i < 400 && !oDone; i++) tick();
        check("t6b_done", {7'd0, oDone}, 8'h01);
        check("t6b_to", {7'd0, oTimeout}, 8'h01);
        check("t6b_pulses", 8'(enPulses - base), 8'd4);
        check("t6b_rw", {7'd0, lcdBus.LCD_RW}, 8'h00);
        check("t6b_data", oDATA, 8'hFF);
        lcdBus.LCD_DATA_IN = 8'h12;
        start_read(1'b1, 1'b0);
        check("t6b_to_clr", {7'd0, oTimeout}, 8'h00);
        repeat (21) tick();
        check("t6b_next_data", oDATA, 8'h12);
`else
        // 6: iPoll ignored without the poll feature
        lcdBus.LCD_DATA_IN = 8'hFF;
        base = enPulses;
        start_read(1'b1, 1'b1);
        repeat (21) tick();
        check("t6_done", {7'd0, oDone}, 8'h01);
        check("t6_pulses", 8'(enPulses - base), 8'd1);
        check("t6_to", {7'd0, oTimeout}, 8'h00);
        check("t6_rs", {7'd0, lcdBus.LCD_RS}, 8'h01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
